rf_write_arbiter: RTL

// Merges the two register-file write sources into the single regfile write port (w: wen/addr/wd).
// - Source 1: the in-order pipeline writeback. It never stalls and always has priority.
// - Source 2: long-latency completions (div, uncached load), buffered in a FIFO with valid/ready.

---
 rtl/rf_write_arbiter_if.sv | 32 +++
 rtl/rf_write_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - regfile write arbiter signal bundle
// master drives the pipeline, long-latency and mark inputs; slave is the arbiter.
interface rf_write_arbiter_if;
  logic        pipe_wen;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_wd;
  logic        lat_valid;
  logic        lat_ready;
  logic [4:0]  lat_addr;
  logic [31:0] lat_wd;
  logic        mark_valid;
  logic [4:0]  mark_addr;
  logic [31:0] busy;
  logic        stall_req;
  logic        w_wen;
  logic [4:0]  w_addr;
  logic [31:0] w_wd;

  modport master (
    output pipe_wen, pipe_addr, pipe_wd,
    output lat_valid, lat_addr, lat_wd,
    output mark_valid, mark_addr,
    input  lat_ready, busy, stall_req, w_wen, w_addr, w_wd
  );

  modport slave (
    input  pipe_wen, pipe_addr, pipe_wd,
    input  lat_valid, lat_addr, lat_wd,
    input  mark_valid, mark_addr,
    output lat_ready, busy, stall_req, w_wen, w_addr, w_wd
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - merges pipeline writeback and long-latency FIFO onto one regfile port
// Pipeline always wins; buffered completions drain on free cycles, with busy scoreboard and starvation stall.
module rf_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input logic             clk,
  input logic             reset,
  rf_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    fifo_addr [FIFO_DEPTH];
  logic [31:0]   fifo_wd   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [SW-1:0] starve;
  logic [SW-1:0] starve_nxt;
  logic [31:0]   busy_q;
  logic [31:0]   busy_nxt;
  logic          stall_q;
  logic          w_wen_q;
  logic [4:0]    w_addr_q;
  logic [31:0]   w_wd_q;

  logic fifo_ne;
  logic ready;
  logic push;
  logic pipe_eff;
  logic pop;
  logic [4:0] head_addr;

  assign fifo_ne   = (count != '0);
  assign ready     = (count < CW'(FIFO_DEPTH));
  // Accepted entries for $0 are swallowed without occupying a slot.
  assign push      = bus.lat_valid && ready && (bus.lat_addr != 5'd0);
  assign pipe_eff  = bus.pipe_wen && (bus.pipe_addr != 5'd0);
  assign pop       = !pipe_eff && fifo_ne;
  assign head_addr = fifo_addr[rd_ptr];

  assign bus.lat_ready = ready;
  assign bus.busy      = busy_q;
  assign bus.stall_req = stall_q;
  assign bus.w_wen     = w_wen_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.w_wd      = w_wd_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.lat_addr;
      fifo_wd[wr_ptr]   <= bus.lat_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new reservation in the same cycle as a pop of that register must survive.
  always_comb begin
    busy_nxt = busy_q;
    if (pop) busy_nxt[head_addr] = 1'b0;
    if (bus.mark_valid && (bus.mark_addr != 5'd0)) busy_nxt[bus.mark_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    starve_nxt = starve;
    if (!fifo_ne || pop) starve_nxt = '0;
    else if (starve != SW'(STARVE_MAX)) starve_nxt = starve + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      starve  <= '0;
      stall_q <= 1'b0;
    end else begin
      busy_q  <= busy_nxt;
      starve  <= starve_nxt;
      stall_q <= (starve_nxt == SW'(STARVE_MAX));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_wen_q  <= 1'b0;
      w_addr_q <= '0;
      w_wd_q   <= '0;
    end else if (pipe_eff) begin
      w_wen_q  <= 1'b1;
      w_addr_q <= bus.pipe_addr;
      w_wd_q   <= bus.pipe_wd;
    end else if (pop) begin
      w_wen_q  <= 1'b1;
      w_addr_q <= head_addr;
      w_wd_q   <= fifo_wd[rd_ptr];
    end else begin
      w_wen_q  <= 1'b0;
    end
  end
endmodule
